// File: rtl/hist_cdf_unit.sv
// Pixel histogram + cumulative distribution with a registered read port.
// Optional equalisation map memory is built when HIST_EQ_MAP_EN is defined.
module hist_cdf_unit #(
  parameter int PIX_W     = 8,
  parameter int CNT_W     = 16,
  parameter int LOG2_NPIX = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             in_last,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pix_count,
  output logic             overflow,
  input  logic [PIX_W-1:0] rd_addr,
  input  logic [1:0]       rd_sel,
  output logic [CNT_W-1:0] rd_data
);
  localparam int BINS = 1 << PIX_W;
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ACCUM, S_DRAIN, S_CDF, S_READY} state_t;

  state_t             state_q, state_d;
  logic [PIX_W-1:0]   idx_q, idx_d;
  logic               s1_vld_q, s1_vld_d;
  logic [PIX_W-1:0]   s1_pix_q, s1_pix_d;
  logic [CNT_W-1:0]   s1_val_q, s1_val_d;
  logic [CNT_W-1:0]   pix_count_q, pix_count_d;
  logic               overflow_q, overflow_d;
  logic [CNT_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   rd_data_q, rd_data_d;
  logic               done_q, done_d;

  logic [CNT_W-1:0]   hist_mem [BINS];
  logic [CNT_W-1:0]   cdf_mem  [BINS];

  logic               accept;
  logic [CNT_W-1:0]   s1_inc;
  logic [CNT_W:0]     cdf_add;
  logic [CNT_W-1:0]   cdf_sat;
  logic               hist_we;
  logic [PIX_W-1:0]   hist_wa;
  logic [CNT_W-1:0]   hist_wd;

  assign accept  = in_valid && (state_q == S_ACCUM);
  assign s1_inc  = (s1_val_q == CMAX) ? CMAX : s1_val_q + 1'b1;
  assign cdf_add = {1'b0, sum_q} + {1'b0, hist_mem[idx_q]};
  assign cdf_sat = cdf_add[CNT_W] ? CMAX : cdf_add[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      s1_vld_q    <= 1'b0;
      s1_pix_q    <= '0;
      s1_val_q    <= '0;
      pix_count_q <= '0;
      overflow_q  <= 1'b0;
      sum_q       <= '0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      s1_vld_q    <= s1_vld_d;
      s1_pix_q    <= s1_pix_d;
      s1_val_q    <= s1_val_d;
      pix_count_q <= pix_count_d;
      overflow_q  <= overflow_d;
      sum_q       <= sum_d;
      rd_data_q   <= rd_data_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_READY: if (start) state_d = S_CLEAR;
      S_CLEAR:         if (idx_q == '1) state_d = S_ACCUM;
      S_ACCUM:         if (accept && in_last) state_d = S_DRAIN;
      S_DRAIN:         if (idx_q[0]) state_d = S_CDF;
      S_CDF:           if (idx_q == '1) state_d = S_READY;
      default:         state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idx_d       = idx_q;
    pix_count_d = pix_count_q;
    overflow_d  = overflow_q;
    sum_d       = sum_q;
    case (state_q)
      S_IDLE, S_READY: if (start) begin
        idx_d       = '0;
        pix_count_d = '0;
        overflow_d  = 1'b0;
      end
      S_CLEAR: idx_d = idx_q + 1'b1;
      S_DRAIN: begin
        idx_d = idx_q[0] ? '0 : idx_q + 1'b1;
        sum_d = '0;
      end
      S_CDF: begin
        idx_d = idx_q + 1'b1;
        sum_d = cdf_sat;
        if (cdf_add[CNT_W]) overflow_d = 1'b1;
      end
      default: ;
    endcase
    if (accept) begin
      if (pix_count_q == CMAX) overflow_d = 1'b1;
      else                     pix_count_d = pix_count_q + 1'b1;
    end
    if (s1_vld_q && s1_val_q == CMAX) overflow_d = 1'b1;
    done_d = (state_q == S_CDF) && (idx_q == '1);
  end

  // Read stage; the bin still being written back is forwarded so repeats all count.
  always_comb begin
    s1_vld_d = accept;
    s1_pix_d = s1_pix_q;
    s1_val_d = s1_val_q;
    if (accept) begin
      s1_pix_d = in_pixel;
      s1_val_d = (s1_vld_q && s1_pix_q == in_pixel) ? s1_inc : hist_mem[in_pixel];
    end
    hist_we = 1'b0;
    hist_wa = s1_pix_q;
    hist_wd = s1_inc;
    if (state_q == S_CLEAR) begin
      hist_we = 1'b1;
      hist_wa = idx_q;
      hist_wd = '0;
    end else if (s1_vld_q) begin
      hist_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (hist_we) hist_mem[hist_wa] <= hist_wd;
    if (state_q == S_CDF) cdf_mem[idx_q] <= cdf_sat;
  end

`ifdef HIST_EQ_MAP_EN
  localparam logic [CNT_W+PIX_W-1:0] PMAX = (CNT_W+PIX_W)'(BINS - 1);
  logic [PIX_W-1:0]       map_mem [BINS];
  logic [CNT_W+PIX_W-1:0] map_prod, map_shift;
  logic [PIX_W-1:0]       map_wd;

  assign map_prod  = (CNT_W+PIX_W)'(cdf_sat) * PMAX;
  assign map_shift = map_prod >> LOG2_NPIX;
  assign map_wd    = (map_shift > PMAX) ? '1 : map_shift[PIX_W-1:0];

  always_ff @(posedge clk) begin
    if (state_q == S_CDF) map_mem[idx_q] <= map_wd;
  end
`endif

  always_comb begin
    rd_data_d = '0;
    if (state_q == S_READY) begin
      case (rd_sel)
        2'd0:    rd_data_d = hist_mem[rd_addr];
        2'd1:    rd_data_d = cdf_mem[rd_addr];
`ifdef HIST_EQ_MAP_EN
        2'd2:    rd_data_d = CNT_W'(map_mem[rd_addr]);
`endif
        default: rd_data_d = '0;
      endcase
    end
  end

  always_comb begin
    in_ready = (state_q == S_ACCUM);
    busy     = (state_q == S_CLEAR) || (state_q == S_ACCUM) ||
               (state_q == S_DRAIN) || (state_q == S_CDF);
  end

  assign done      = done_q;
  assign pix_count = pix_count_q;
  assign overflow  = overflow_q;
  assign rd_data   = rd_data_q;
endmodule

// File: tb/tb_hist_cdf_unit.sv
// Bench for hist_cdf_unit: a default instance plus a CNT_W=4 / LOG2_NPIX=2 instance,
// one of which is targeted at a time; a frame-level model predicts every read.
module tb_hist_cdf_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic s_start = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0;
  logic [7:0] in_pixel = '0, rd_addr = '0;
  logic [1:0] rd_sel = '0;
  int tgt = 0;

  logic start0, start1;
  logic ir0, ir1, busy0, busy1, done0, done1, ov0, ov1;
  logic [15:0] pc0, rd0;
  logic [3:0]  pc1, rd1;

  assign start0 = s_start && (tgt == 0);
  assign start1 = s_start && (tgt == 1);

  hist_cdf_unit dut0 (
    .clk(clk), .reset(reset), .start(start0), .in_valid(in_valid), .in_ready(ir0),
    .in_pixel(in_pixel), .in_last(in_last), .busy(busy0), .done(done0),
    .pix_count(pc0), .overflow(ov0), .rd_addr(rd_addr), .rd_sel(rd_sel), .rd_data(rd0));

  hist_cdf_unit #(.PIX_W(8), .CNT_W(4), .LOG2_NPIX(2)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .in_valid(in_valid), .in_ready(ir1),
    .in_pixel(in_pixel), .in_last(in_last), .busy(busy1), .done(done1),
    .pix_count(pc1), .overflow(ov1), .rd_addr(rd_addr), .rd_sel(rd_sel), .rd_data(rd1));

  always #5 clk = ~clk;

  wire        ir_t   = tgt ? ir1   : ir0;
  wire        busy_t = tgt ? busy1 : busy0;
  wire        done_t = tgt ? done1 : done0;
  wire        ov_t   = tgt ? ov1   : ov0;
  wire [15:0] pc_t   = tgt ? 16'(pc1) : pc0;
  wire [15:0] rd_t   = tgt ? 16'(rd1) : rd0;

  int n_chk = 0, n_fail = 0;
  int q[$];
  int m_h[256], m_c[256], m_m[256];
  int m_pc = 0;
  bit m_ov = 0;
  // 0: read port must return 0, 1: read port returns model data, 2: unchecked
  int chk_mode = 2;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame model straight from the rules: saturating counts, running sum, map.
  task automatic compute_model();
    int maxv, lg, sum, mv;
    maxv = tgt ? 15 : 65535;
    lg   = tgt ? 2 : 16;
    m_ov = 0;
    for (int b = 0; b < 256; b++) m_h[b] = 0;
    foreach (q[i]) begin
      if (m_h[q[i]] < maxv) m_h[q[i]]++;
      else m_ov = 1;
    end
    m_pc = (q.size() > maxv) ? maxv : q.size();
    if (q.size() > maxv) m_ov = 1;
    sum = 0;
    for (int b = 0; b < 256; b++) begin
      sum += m_h[b];
      if (sum > maxv) begin sum = maxv; m_ov = 1; end
      m_c[b] = sum;
      mv = int'((longint'(sum) * 255) >> lg);
      m_m[b] = (mv > 255) ? 255 : mv;
    end
  endtask

  function automatic int model_rd(input logic [1:0] sel, input logic [7:0] a);
    case (sel)
      2'd0: return m_h[a];
      2'd1: return m_c[a];
`ifdef HIST_EQ_MAP_EN
      2'd2: return m_m[a];
`endif
      default: return 0;
    endcase
  endfunction

  int cap_mode = 2, cap_exp = 0;
  always @(posedge clk) begin
    cap_mode <= chk_mode;
    cap_exp  <= model_rd(rd_sel, rd_addr);
  end

  always @(negedge clk) begin
    if (cap_mode == 0) chk("rd_data_idle", int'(rd_t), 0);
    else if (cap_mode == 1) begin
      chk("rd_data_model", int'(rd_t), cap_exp);
      if (chk_mode == 1) begin
        chk("pix_count_model", int'(pc_t), m_pc);
        chk("overflow_model", int'(ov_t), int'(m_ov));
      end
    end
  end

  task automatic do_start();
    @(negedge clk);
    s_start = 1'b1;
    @(posedge clk);
    #1;
    s_start = 1'b0;
    chk_mode = 0;
    q.delete();
  endtask

  task automatic feed(input int p, input bit last, input bit gaps);
    int n;
    if (gaps) begin
      n = $urandom_range(0, 2);
      repeat (n) @(negedge clk);
    end
    in_valid = 1'b1;
    in_pixel = 8'(p);
    in_last  = last;
    n = 0;
    while (!ir_t && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) chk("in_ready_timeout", 0, 1);
    @(posedge clk);
    q.push_back(p);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done_t && n < 5000) begin @(negedge clk); n++; end
    chk("done_seen", int'(done_t), 1);
    compute_model();
    chk_mode = 1;
    @(negedge clk);
    chk("done_one_cycle", int'(done_t), 0);
    chk("busy_ready", int'(busy_t), 0);
  endtask

  task automatic rd(input int sel, input int a, output int v);
    @(negedge clk);
    rd_sel = 2'(sel);
    rd_addr = 8'(a);
    @(negedge clk);
    v = int'(rd_t);
  endtask

  task automatic sweep();
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 256; a++) begin
        @(negedge clk);
        rd_sel = 2'(s);
        rd_addr = 8'(a);
      end
  endtask

  int v;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_mode = 0;
    chk("rst_busy", int'(busy0), 0);
    chk("rst_in_ready", int'(ir0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_pix_count", int'(pc0), 0);
    chk("rst_overflow", int'(ov0), 0);
    chk("rst_rd_data", int'(rd0), 0);
    reset = 1'b0;

    // Frame 5,5,5,7 back-to-back; in_ready exactly after 256 clear cycles
    do_start();
    chk("t1_busy_after_start", int'(busy0), 1);
    chk("t1_ready_in_clear", int'(ir0), 0);
    repeat (255) @(posedge clk);
    #1 chk("t1_ready_clear_last", int'(ir0), 0);
    @(posedge clk);
    #1 chk("t1_ready_accum", int'(ir0), 1);
    @(negedge clk);
    feed(5, 0, 0); feed(5, 0, 0); feed(5, 0, 0); feed(7, 1, 0);
    wait_done();
    rd(0, 5, v);   chk("t1_hist5", v, 3);
    rd(0, 7, v);   chk("t1_hist7", v, 1);
    rd(0, 0, v);   chk("t1_hist0", v, 0);
    rd(1, 4, v);   chk("t1_cdf4", v, 0);
    rd(1, 5, v);   chk("t1_cdf5", v, 3);
    rd(1, 6, v);   chk("t1_cdf6", v, 3);
    rd(1, 255, v); chk("t1_cdf255", v, 4);
    rd(3, 5, v);   chk("t1_sel3", v, 0);
    chk("t1_pix_count", int'(pc0), 4);
    chk("t1_overflow", int'(ov0), 0);
    sweep();

    // 1000 zeros + 1 with gaps; stray start mid-ACCUM; reads while busy are 0
    do_start();
    rd(1, 255, v); chk("t2_rd_busy", v, 0);
    for (int i = 0; i < 1000; i++) begin
      feed(0, 0, 1);
      if (i == 500) begin
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        chk("t2_busy_after_stray_start", int'(busy0), 1);
      end
    end
    feed(1, 1, 1);
    wait_done();
    rd(0, 0, v);   chk("t2_hist0", v, 1000);
    rd(0, 1, v);   chk("t2_hist1", v, 1);
    rd(1, 255, v); chk("t2_cdf255", v, 1001);
    chk("t2_pix_count", int'(pc0), 1001);

    // Saturation on the CNT_W=4 instance
    chk_mode = 2;
    @(negedge clk);
    tgt = 1;
    repeat (2) @(negedge clk);
    do_start();
    for (int i = 0; i < 20; i++) feed(3, i == 19, 0);
    wait_done();
    rd(0, 3, v);   chk("t3_hist3", v, 15);
    rd(1, 2, v);   chk("t3_cdf2", v, 0);
    rd(1, 3, v);   chk("t3_cdf3", v, 15);
    rd(1, 255, v); chk("t3_cdf255", v, 15);
    chk("t3_pix_count", int'(pc_t), 15);
    chk("t3_overflow", int'(ov_t), 1);
    sweep();

    // Map frame 0,0,128,255 with LOG2_NPIX=2
    do_start();
    feed(0, 0, 0); feed(0, 0, 0); feed(128, 0, 0); feed(255, 1, 0);
    wait_done();
    chk("t5_overflow", int'(ov_t), 0);
`ifdef HIST_EQ_MAP_EN
    rd(2, 0, v);   chk("t5_map0", v, 127);
    rd(2, 127, v); chk("t5_map127", v, 127);
    rd(2, 128, v); chk("t5_map128", v, 191);
    rd(2, 255, v); chk("t5_map255", v, 255);
`else
    rd(2, 0, v);   chk("t5_map_absent0", v, 0);
    rd(2, 255, v); chk("t5_map_absent255", v, 0);
`endif
    sweep();

    // Reset in the middle of a frame, then a fresh frame
    chk_mode = 2;
    @(negedge clk);
    tgt = 0;
    repeat (2) @(negedge clk);
    do_start();
    for (int i = 0; i < 10; i++) feed(9, 0, 0);
    chk_mode = 0;
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_busy", int'(busy0), 0);
    chk("t6_rst_in_ready", int'(ir0), 0);
    chk("t6_rst_pix_count", int'(pc0), 0);
    chk("t6_rst_overflow", int'(ov0), 0);
    chk("t6_rst_done", int'(done0), 0);
    chk("t6_rst_rd_data", int'(rd0), 0);
    @(negedge clk);
    reset = 1'b0;
    do_start();
    feed(2, 0, 0); feed(2, 1, 0);
    wait_done();
    rd(0, 9, v);   chk("t6_hist9", v, 0);
    rd(0, 2, v);   chk("t6_hist2", v, 2);
    rd(1, 255, v); chk("t6_cdf255", v, 2);
    chk("t6_pix_count", int'(pc0), 2);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
